collision_arbiter: RTL



---
 rtl/collision_arbiter_pkg.sv | 31 +++
 rtl/collision_arbiter_if.sv | 48 ++++
 rtl/collision_arbiter_aabb_overlap.sv | 29 ++
 rtl/collision_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/collision_arbiter_pkg.sv
// Shared types and helpers for the collision arbiter.
// Sprite state enums, controller states, counter width.
package collision_pkg;

  typedef enum logic {
    P_ALIVE,
    P_DEAD
  } player_state_t;

  typedef enum logic [1:0] {
    E_DEAD,
    E_ALIVE,
    E_SQUASHED
  } enemy_state_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_SCAN,
    C_COMMIT
  } ctrl_state_t;

  function automatic int cnt_width(
    input int sq,
    input int inv
  );
    int m;
    m = (sq > inv) ? sq : inv;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/collision_arbiter_if.sv
// Sprite/game-state bus of the collision arbiter.
// master: motion controllers + score logic; slave: arbiter.
interface collision_arbiter_if #(
  parameter int NP = 2,
  parameter int NE = 4,
  parameter int CW = 10
);
  logic             frame_tick;
  logic [NP*CW-1:0] player_x;
  logic [NP*CW-1:0] player_y;
  logic [NP*CW-1:0] player_vy;
  logic [NP-1:0]    player_revive;
  logic [NE*CW-1:0] enemy_x;
  logic [NE*CW-1:0] enemy_y;
  logic [NE-1:0]    enemy_spawn;
  logic [CW-1:0]    scroll_pos;
  logic [NP-1:0]    player_dead;
  logic [NP-1:0]    player_invuln;
  logic [NP-1:0]    stomp_bounce;
  logic [NE-1:0]    enemy_alive;
  logic [NE-1:0]    enemy_squashed;
  logic [3:0]       score_inc;
  logic             busy;
  logic             done;
  logic             overrun;

  modport master (
    output frame_tick, player_x, player_y,
    output player_vy, player_revive,
    output enemy_x, enemy_y, enemy_spawn,
    output scroll_pos,
    input  player_dead, player_invuln,
    input  stomp_bounce, enemy_alive,
    input  enemy_squashed, score_inc,
    input  busy, done, overrun
  );

  modport slave (
    input  frame_tick, player_x, player_y,
    input  player_vy, player_revive,
    input  enemy_x, enemy_y, enemy_spawn,
    input  scroll_pos,
    output player_dead, player_invuln,
    output stomp_bounce, enemy_alive,
    output enemy_squashed, score_inc,
    output busy, done, overrun
  );
endinterface

// File: rtl/collision_arbiter_aabb_overlap.sv
// Combinational axis-aligned box overlap test.
// Ports: box A/B origins in, hit out.
module aabb_overlap #(
  parameter int COORD_W = 10,
  parameter int A_W     = 26,
  parameter int A_H     = 32,
  parameter int B_W     = 32,
  parameter int B_H     = 32
) (
  input  logic [COORD_W-1:0] ax,
  input  logic [COORD_W-1:0] ay,
  input  logic [COORD_W-1:0] bx,
  input  logic [COORD_W-1:0] by,
  output logic               hit
);
  localparam int W = COORD_W + 1;

  logic [W-1:0] ax1, ay1, bx1, by1;

  assign ax1 = {1'b0, ax};
  assign ay1 = {1'b0, ay};
  assign bx1 = {1'b0, bx};
  assign by1 = {1'b0, by};

  assign hit = (ax1 < bx1 + W'(B_W))
            && (bx1 < ax1 + W'(A_W))
            && (ay1 < by1 + W'(B_H))
            && (by1 < ay1 + W'(A_H));
endmodule

// File: rtl/collision_arbiter.sv
// Frame-based player/enemy collision resolver.
// Ports: Clk, Reset_n, bus (slave side of arbiter bus).
module collision_arbiter
  import collision_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int NUM_ENEMIES   = 4,
  parameter int COORD_W       = 10,
  parameter int PLAYER_W      = 26,
  parameter int PLAYER_H      = 32,
  parameter int ENEMY_W       = 32,
  parameter int ENEMY_H       = 32,
  parameter int SQUASH_FRAMES = 16,
  parameter int INVULN_FRAMES = 60
) (
  input logic          Clk,
  input logic          Reset_n,
  collision_arbiter_if.slave bus
);
  localparam int NP = NUM_PLAYERS;
  localparam int NE = NUM_ENEMIES;
  localparam int CW = COORD_W;
  localparam int PIW = (NP > 1) ? $clog2(NP) : 1;
  localparam int EIW = (NE > 1) ? $clog2(NE) : 1;
  localparam int CNT_W =
    cnt_width(SQUASH_FRAMES, INVULN_FRAMES);

  ctrl_state_t state, state_n;
  logic tick_ok, scan_en, commit_en, last_pair;
  logic [PIW-1:0] pi;
  logic [EIW-1:0] ei;

  logic [NP*CW-1:0] s_px, s_py, s_vy;
  logic [NE*CW-1:0] s_ex, s_ey;
  logic [CW-1:0]    s_scroll;
  logic [NP-1:0]    s_palive, s_pinv;
  logic [NE-1:0]    s_ealive;
  logic [NP*NE-1:0] stomp, side;

  player_state_t    p_st  [NP];
  logic [CNT_W-1:0] p_inv [NP];
  enemy_state_t     e_st  [NE];
  logic [CNT_W-1:0] e_cnt [NE];
  enemy_state_t     e_nst [NE];
  logic [CNT_W-1:0] e_ncnt[NE];

  logic [CW-1:0] cur_px, cur_py, cur_vy;
  logic [CW-1:0] cur_ex, cur_ey;
  logic hit, stomp_now, side_now;
  logic [NE-1:0] stomped_e;
  logic [NP-1:0] bounce_p, hit_p;
  logic [3:0]    score;
  logic          done_q, overrun_q;
  logic [NP-1:0] bounce_q;
  logic [3:0]    score_q;

  // A tick in the done cycle still counts as busy.
  assign tick_ok = bus.frame_tick
                && (state == C_IDLE) && !done_q;
  assign last_pair = (pi == PIW'(NP - 1))
                  && (ei == EIW'(NE - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= C_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n   = state;
    scan_en   = 1'b0;
    commit_en = 1'b0;
    unique case (state)
      C_IDLE:   if (tick_ok) state_n = C_SCAN;
      C_SCAN: begin
        scan_en = 1'b1;
        if (last_pair) state_n = C_COMMIT;
      end
      C_COMMIT: begin
        commit_en = 1'b1;
        state_n   = C_IDLE;
      end
      default:  state_n = C_IDLE;
    endcase
  end

  assign cur_px = s_px[int'(pi)*CW +: CW];
  assign cur_py = s_py[int'(pi)*CW +: CW];
  assign cur_vy = s_vy[int'(pi)*CW +: CW];
  assign cur_ex = s_ex[int'(ei)*CW +: CW];
  assign cur_ey = s_ey[int'(ei)*CW +: CW];

  aabb_overlap #(
    .COORD_W (CW),
    .A_W     (PLAYER_W),
    .A_H     (PLAYER_H),
    .B_W     (ENEMY_W),
    .B_H     (ENEMY_H)
  ) u_aabb (
    .ax  (cur_px),
    .ay  (cur_py),
    .bx  (cur_ex),
    .by  (cur_ey),
    .hit (hit)
  );

  assign stomp_now = hit && !cur_vy[CW-1] && |cur_vy
                  && s_palive[pi] && s_ealive[ei];
  assign side_now  = hit && !stomp_now
                  && s_ealive[ei] && s_palive[pi]
                  && !s_pinv[pi];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pi <= '0;
      ei <= '0;
      s_px <= '0;
      s_py <= '0;
      s_vy <= '0;
      s_ex <= '0;
      s_ey <= '0;
      s_scroll <= '0;
      s_palive <= '0;
      s_pinv <= '0;
      s_ealive <= '0;
      stomp <= '0;
      side <= '0;
    end else if (tick_ok) begin
      pi <= '0;
      ei <= '0;
      s_px <= bus.player_x;
      s_py <= bus.player_y;
      s_vy <= bus.player_vy;
      s_ex <= bus.enemy_x;
      s_ey <= bus.enemy_y;
      s_scroll <= bus.scroll_pos;
      for (int p = 0; p < NP; p++) begin
        s_palive[p] <= (p_st[p] == P_ALIVE);
        s_pinv[p]   <= (p_inv[p] != '0);
      end
      for (int e = 0; e < NE; e++)
        s_ealive[e] <= (e_st[e] == E_ALIVE);
      stomp <= '0;
      side <= '0;
    end else if (scan_en) begin
      stomp[int'(pi)*NE + int'(ei)] <= stomp_now;
      side[int'(pi)*NE + int'(ei)]  <= side_now;
      if (ei == EIW'(NE - 1)) begin
        ei <= '0;
        pi <= pi + 1'b1;
      end else begin
        ei <= ei + 1'b1;
      end
    end
  end

  // Whole-frame resolution from the collected pair bits.
  always_comb begin
    stomped_e = '0;
    bounce_p  = '0;
    hit_p     = '0;
    score     = '0;
    for (int p = 0; p < NP; p++)
      for (int e = 0; e < NE; e++)
        if (stomp[p*NE + e]) begin
          stomped_e[e] = 1'b1;
          bounce_p[p]  = 1'b1;
        end
    for (int p = 0; p < NP; p++)
      for (int e = 0; e < NE; e++)
        if (side[p*NE + e] && !stomped_e[e])
          hit_p[p] = 1'b1;
    for (int e = 0; e < NE; e++)
      score = score + {3'b000, stomped_e[e]};
    for (int e = 0; e < NE; e++) begin
      e_nst[e]  = e_st[e];
      e_ncnt[e] = e_cnt[e];
      if (stomped_e[e]) begin
        e_nst[e]  = E_SQUASHED;
        e_ncnt[e] = CNT_W'(SQUASH_FRAMES);
      end else if (e_st[e] == E_SQUASHED) begin
        e_ncnt[e] = e_cnt[e] - 1'b1;
        if (e_cnt[e] <= CNT_W'(1))
          e_nst[e] = E_DEAD;
      end
      if (e_nst[e] != E_DEAD
          && s_ex[e*CW +: CW] < s_scroll) begin
        e_nst[e]  = E_DEAD;
        e_ncnt[e] = '0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int p = 0; p < NP; p++) begin
        p_st[p]  <= P_ALIVE;
        p_inv[p] <= '0;
      end
      for (int e = 0; e < NE; e++) begin
        e_st[e]  <= E_DEAD;
        e_cnt[e] <= '0;
      end
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      bounce_q  <= '0;
      score_q   <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (bus.player_revive[p]) begin
          p_st[p]  <= P_ALIVE;
          p_inv[p] <= CNT_W'(INVULN_FRAMES);
        end else if (commit_en) begin
          if (hit_p[p]) p_st[p] <= P_DEAD;
          if (p_inv[p] != '0)
            p_inv[p] <= p_inv[p] - 1'b1;
        end
      end
      for (int e = 0; e < NE; e++) begin
        if (bus.enemy_spawn[e]) begin
          e_st[e]  <= E_ALIVE;
          e_cnt[e] <= '0;
        end else if (commit_en) begin
          e_st[e]  <= e_nst[e];
          e_cnt[e] <= e_ncnt[e];
        end
      end
      done_q   <= commit_en;
      bounce_q <= commit_en ? bounce_p : '0;
      score_q  <= commit_en ? score : '0;
      if (bus.frame_tick && !tick_ok)
        overrun_q <= 1'b1;
    end
  end

  always_comb begin
    bus.player_dead    = '0;
    bus.player_invuln  = '0;
    bus.enemy_alive    = '0;
    bus.enemy_squashed = '0;
    for (int p = 0; p < NP; p++) begin
      bus.player_dead[p]   = (p_st[p] == P_DEAD);
      bus.player_invuln[p] = (p_inv[p] != '0);
    end
    for (int e = 0; e < NE; e++) begin
      bus.enemy_alive[e]    = (e_st[e] == E_ALIVE);
      bus.enemy_squashed[e] = (e_st[e] == E_SQUASHED);
    end
  end

  assign bus.stomp_bounce = bounce_q;
  assign bus.score_inc    = score_q;
  assign bus.done         = done_q;
  assign bus.busy         = (state != C_IDLE) || done_q;
  assign bus.overrun      = overrun_q;
endmodule
